// File: rtl/serial_adder_sub.sv
// Bit-serial N-bit adder/subtractor: one result bit per clock, LSB first.
// A start in IDLE latches the operands; done pulses one cycle after the last bit.
module serial_adder_sub #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] ip1,
    input  logic [N-1:0] ip2,
    input  logic         c_in,
    output logic [N-1:0] answer,
    output logic         c_out,
    output logic         overflow,
    output logic         busy,
    output logic         done
);

    localparam int unsigned KW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic            carry;
    logic [KW-1:0]   k;

    logic            sum_c;
    logic            maj_c;
    logic            last_c;

    // Full-adder slice for the current bit position
    always_comb begin
        sum_c  = a_reg[k] ^ b_reg[k] ^ carry;
        maj_c  = (a_reg[k] & b_reg[k]) | (a_reg[k] & carry) | (b_reg[k] & carry);
        last_c = (k == KW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_c) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered status; busy/done track the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            k        <= '0;
            answer   <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= ip1;
                        b_reg <= ip2 ^ {N{c_in}};
                        carry <= c_in;
                        k     <= '0;
                    end
                end
                RUN: begin
                    answer[k] <= sum_c;
                    carry     <= maj_c;
                    k         <= k + KW'(1);
                    if (last_c) begin
                        c_out    <= maj_c;
                        overflow <= carry ^ maj_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_sub.sv
// Scoreboard bench for serial_adder_sub (N=32): directed vectors push expected
// results; a negedge monitor pops and compares on every done pulse.
module tb_serial_adder_sub;

    localparam int unsigned N = 32;

    typedef struct packed {
        logic [N-1:0] answer;
        logic         c_out;
        logic         overflow;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] ip1;
    logic [N-1:0] ip2;
    logic         c_in;
    logic [N-1:0] answer;
    logic         c_out;
    logic         overflow;
    logic         busy;
    logic         done;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int   cyc = 0;
    int   busy_run = 0;
    logic aborted = 1'b0;
    logic prev_done = 1'b0;
    logic b2b_mode = 1'b0;
    int   last_done_cyc = -1;

    serial_adder_sub #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ip1      (ip1),
        .ip2      (ip2),
        .c_in     (c_in),
        .answer   (answer),
        .c_out    (c_out),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: result scoreboard, done width, busy length, done spacing
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) aborted = 1'b1;
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: actual=done with empty scoreboard required=no done");
            end else begin
                e = exp_q.pop_front();
                check("answer", answer, e.answer);
                check("c_out", N'(c_out), N'(e.c_out));
                check("overflow", N'(overflow), N'(e.overflow));
            end
            if (prev_done) check("done_width", 32'd2, 32'd1);
            if (b2b_mode && last_done_cyc >= 0) check("b2b_spacing", N'(cyc - last_done_cyc), N'(34));
            last_done_cyc = cyc;
        end
        if (busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            if (!aborted) check("busy_len", N'(busy_run), N'(N));
            busy_run = 0;
        end
        if (!busy && !reset) aborted = 1'b0;
        prev_done = done;
    end

    // Issue one op from IDLE, push its expected result, wait (bounded) for done
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic m,
                         input logic [N-1:0] ans, input logic co, input logic ov);
        int cnt;
        exp_t e;
        e.answer = ans; e.c_out = co; e.overflow = ov;
        exp_q.push_back(e);
        ip1 = a; ip2 = b; c_in = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ip1 = ~a; ip2 = ~b; c_in = ~m;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (done || cnt >= 100) break;
            @(posedge clk); #1;
            cnt++;
        end
        check("latency", N'(cnt), N'(N));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        exp_t e;
        reset = 1'b1; start = 1'b0; ip1 = '0; ip2 = '0; c_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; ip1 = 32'hFFFF_FFFF; ip2 = 32'hFFFF_FFFF;
        @(negedge clk);
        check("rst_answer", answer, '0);
        check("rst_flags", N'({c_out, overflow, busy, done}), '0);
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;

        do_op(32'd2014, 32'd1167, 1'b0, 32'd3181, 1'b0, 1'b0);
        do_op(32'd2014, 32'd1167, 1'b1, 32'd847, 1'b1, 1'b0);
        do_op(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        do_op(32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        do_op(32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, 1'b0);

        // Start and operand changes during RUN must be ignored
        e.answer = 32'd8; e.c_out = 1'b0; e.overflow = 1'b0;
        exp_q.push_back(e);
        ip1 = 32'd5; ip2 = 32'd3; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        ip1 = 32'd100; ip2 = 32'd1; c_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("ignored_start_drained", N'(exp_q.size()), '0);

        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1);

        // Abort mid-RUN with reset; outputs cleared, no done
        ip1 = 32'h0000_FFFF; ip2 = 32'd0; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_answer", answer, '0);
        check("abort_flags", N'({c_out, overflow, busy, done}), '0);
        @(posedge clk); #1;
        do_op(32'd9, 32'd4, 1'b1, 32'd5, 1'b1, 1'b0);

        // Back-to-back with start held high: three accepted ops 34 cycles apart
        b2b_mode = 1'b1;
        last_done_cyc = -1;
        for (int i = 0; i < 3; i++) begin
            e.answer = 32'd3; e.c_out = 1'b0; e.overflow = 1'b0;
            exp_q.push_back(e);
        end
        ip1 = 32'd1; ip2 = 32'd2; c_in = 1'b0; start = 1'b1;
        repeat (102) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        b2b_mode = 1'b0;

        check("scoreboard_empty", N'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_sub.md
SERIAL_ADDER_SUB -- requirements
Module: serial_adder_sub

Interface
REQ-001 Parameter: N, default 32, operand and result width in bits (N >= 2).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 ip1  input  N  first operand (minuend for subtraction).
REQ-006 ip2  input  N  second operand (subtrahend for subtraction).
REQ-007 c_in  input  1  mode select, sampled with start: 0 = ip1+ip2, 1 = ip1-ip2.
REQ-008 answer  output  N  result, two's complement wrap modulo 2^N.
REQ-009 c_out  output  1  carry out of bit N-1 (for subtraction, 1 = no borrow, i.e. ip1 >= ip2 unsigned).
REQ-010 overflow  output  1  signed overflow flag.
REQ-011 busy  output  1  high while an operation is in progress (RUN state).
REQ-012 done  output  1  one-cycle pulse marking that answer, c_out and overflow are valid.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE with start=1 at an edge SHALL latch A=ip1, B=ip2 XOR {N{c_in}}, carry=c_in, bit index k=0, and enter RUN.
REQ-015 IDLE with start=0 SHALL hold all outputs unchanged.
REQ-016 Each RUN edge SHALL compute one result bit, LSB first:
- s = A[k]^B[k]^carry
- carry <= majority(A[k], B[k], carry)
- answer[k] <= s
- k <= k+1
REQ-017 At the RUN edge processing k=N-1, the block SHALL:
- record the carry into bit N-1 (cin_msb)
- set c_out to the new carry
- set overflow = cin_msb XOR new carry
- enter DONE
REQ-018 The bit counter SHALL be ceil(log2(N)) bits wide or more and SHALL NOT wrap before k=N-1 is processed.
REQ-019 Latency: with start accepted at edge E0, RUN SHALL occupy edges E1..EN, and done SHALL be high for exactly the one cycle following EN.
REQ-020 DONE SHALL return to IDLE on the next edge; done SHALL be high only in DONE.
REQ-021 busy SHALL be high exactly in RUN (N cycles per operation).
REQ-022 start in RUN or DONE SHALL be ignored (not queued), and ip1, ip2 and c_in changes during RUN SHALL NOT affect the result.
REQ-023 answer, c_out and overflow SHALL keep their final values from DONE until the next accepted start.
REQ-024 answer bits not yet computed during RUN are undefined to consumers; only values qualified by done are valid.
REQ-025 The next operation may start in the IDLE cycle after DONE, giving a throughput of one operation per N+2 cycles.

Reset
REQ-026 With reset=1 at an edge, the block SHALL enter IDLE and clear answer, c_out, overflow, busy, done, the carry and the bit counter, with priority over start.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse; start is honoured from the first edge with reset=0.

Verification (N=32)
REQ-028 ip1=2014, ip2=1167, c_in=0, start -> done 32 cycles later; answer=3181, c_out=0, overflow=0, busy high for exactly 32 cycles.
REQ-029 ip1=2014, ip2=1167, c_in=1 -> answer=847, c_out=1, overflow=0.
REQ-030 Boundary operations:
- 0x7FFFFFFF + 1 -> 0x80000000, overflow=1, c_out=0
- 0xFFFFFFFF + 1 -> 0x00000000, c_out=1, overflow=0
- 0x80000000 - 1 -> 0x7FFFFFFF, overflow=1, c_out=1
- 0 - 1 -> 0xFFFFFFFF, c_out=0, overflow=0
REQ-031 Start accepted with 5+3, then start pulsed with ip1=100, ip2=1 at cycle 10 of RUN -> single done pulse, answer=8; the second start is ignored.
REQ-032 Reset asserted at cycle 16 of RUN -> next cycle all outputs 0, no done pulse; a following start for 9-4 -> answer=5, c_out=1.
REQ-033 Back-to-back: start held high continuously -> operations complete every 34 cycles, each done exactly one cycle wide.
